johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
- Receive-side companion of the twisted-ring (Johnson) counter.
- Samples a WIDTH-bit Johnson code each valid clock and decodes it to a binary index and a one-hot vector.
- Checks code legality and that successive codes follow the ring order, and keeps lock state and an error count.
- Sits downstream of any Johnson-counter stage to monitor it and convert it to binary.

Parameters:
- WIDTH, 5, ring length in flip-flops; the sequence has 2*WIDTH states.
- IW, 4, index width; must satisfy 2^IW >= 2*WIDTH.
- LOCK_COUNT, 2, number of consecutive in-order legal codes needed to enter LOCKED.
- ALLOW_HOLD, 1, when 1 a repeat of the previous code is not a sequence error.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- code  input  WIDTH  Johnson code; code[0] is the first stage (fed by ~code[WIDTH-1]).
- code_valid  input  1  code is sampled on this clock edge.
- index  output  IW  decoded state number, 0..2*WIDTH-1, registered.
- onehot  output  2*WIDTH  onehot[index]=1 when out_valid and legal, else all 0.
- out_valid  output  1  index/onehot/legal refer to a code sampled last cycle.
- legal  output  1  last sampled code is a legal Johnson state.
- seq_err  output  1  one-cycle pulse on an ordering or legality violation while LOCKED.
- locked  output  1  FSM is in LOCKED.
- err_count  output  8  saturating count of seq_err pulses.

Behaviour:

Reset (clear=1, asynchronous, any time):
- index=0, onehot=0, out_valid=0, legal=0, seq_err=0, locked=0, err_count=0.
- FSM goes to UNLOCKED; run counter=0; previous-index register=0.

Code sequence (forward order):
- 00000 -> 00001 -> 00011 -> 00111 -> 01111 -> 11111 -> 11110 -> 11100 -> 11000 -> 10000 -> 00000.
- WIDTH=5 is shown; the pattern generalises to any WIDTH.

Decode:
- If code[WIDTH-1]=0: code is legal only if it has the form 0..01..1; index = popcount(code).
- If code[WIDTH-1]=1: code is legal only if it has the form 1..10..0; index = WIDTH + number of zeros.
- Illegal code: legal=0, index holds its previous value, onehot=0.

Latency and valid handling:
- Latency is one cycle: outputs update on the edge following the sampled edge.
- out_valid = code_valid delayed one cycle.
- When code_valid=0: no state change, and index/legal hold their previous values.

Expected next index:
- nxt = (prev+1) mod 2*WIDTH. Wrap: 2*WIDTH-1 -> 0 is in order.

FSM, evaluated only on code_valid edges:
- UNLOCKED:
  - Illegal code: run counter=0.
  - Legal code, first one seen or equal to nxt: run counter +1.
  - Any other legal code: run counter=1.
  - When run counter reaches LOCK_COUNT: go to LOCKED.
  - seq_err is never asserted in UNLOCKED.
- LOCKED:
  - Legal code equal to nxt: stay in LOCKED.
  - Legal code equal to prev and ALLOW_HOLD=1: stay in LOCKED.
  - Otherwise (illegal code, skip, backward step, or hold with ALLOW_HOLD=0): seq_err=1 for one cycle, err_count+1, go to UNLOCKED, run counter=0.
  - If that code is legal, it reseeds prev and run counter=1.
- err_count saturates at 255 and does not wrap.
- locked is registered and is 1 from the edge that completes LOCK_COUNT.

Simultaneous events:
- clear overrides everything.
- A seq_err and the lock loss occur on the same edge.

Test Plan:
1. Reset state: clear=1 with code=11111, code_valid=1 -> all outputs 0. Release clear -> on the next edge index=5, legal=1, out_valid=1, locked=0.
2. Lock and full wrap: drive the full forward sequence 00000..10000 then 00000, one per clock.
   - index goes 0,1,..,9,0.
   - onehot goes 0x001..0x200,0x001.
   - locked=1 one cycle after the second code.
   - seq_err never asserts; err_count=0.
3. Illegal code while LOCKED: after lock, drive 00101.
   - legal=0, onehot=0, index holds.
   - seq_err pulses for exactly 1 cycle; locked=0; err_count=1.
   - Then 00111, 01111 -> relock, index=3 then 4.
4. Skip and hold while LOCKED:
   - 00011 -> 01111 (skip): seq_err=1, err_count +1.
   - After relock, repeat 11100 twice with ALLOW_HOLD=1: no error.
   - Same repeat with ALLOW_HOLD=0: seq_err=1.
5. Gaps and saturation:
   - code_valid toggled 1,0,1 across an in-order sequence: no error; out_valid follows code_valid delayed by 1.
   - Force 300 errors: err_count stops at 255.
6. Async clear mid-lock: assert clear between clock edges while LOCKED -> locked, err_count and out_valid drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code decoder: converts a WIDTH-bit ring code to a binary index and
// one-hot vector, and monitors ring ordering with a lock FSM and a saturating error count.
module johnson_decoder #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned IW         = 4,
    parameter int unsigned LOCK_COUNT = 2,
    parameter bit          ALLOW_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     code,
    input  logic                 code_valid,
    output logic [IW-1:0]        index,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 out_valid,
    output logic                 legal,
    output logic                 seq_err,
    output logic                 locked,
    output logic [7:0]           err_count
);

    localparam int unsigned NSTATES = 2 * WIDTH;
    localparam int unsigned RW      = $clog2(LOCK_COUNT + 1);

    typedef enum logic {StUnlocked, StLocked} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [RW-1:0]   r_run;
    logic [RW-1:0]   w_run_d;
    logic [IW-1:0]   r_index;
    logic            r_legal;
    logic            r_out_valid;
    logic            r_seq_err;
    logic            w_seq_err_d;
    logic [7:0]      r_err_count;
    logic [7:0]      w_err_count_d;

    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_low_inc;
    logic             w_legal;
    logic [IW-1:0]    w_pop;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_nxt;
    logic             w_is_nxt;
    logic             w_is_hold;
    logic             w_in_order;

    // A legal code, after inverting the upper half of the ring, is a run of ones from bit 0.
    assign w_low     = code[WIDTH-1] ? ~code : code;
    assign w_low_inc = w_low + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_legal   = ((w_low & w_low_inc) == '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + IW'(code[i]);
        end
    end

    // Upper half: WIDTH + zeros == 2*WIDTH - ones.
    assign w_idx = code[WIDTH-1] ? (IW'(NSTATES) - w_pop) : w_pop;

    // r_index only updates on legal codes, so it doubles as the previous-index register.
    assign w_nxt      = (r_index == IW'(NSTATES - 1)) ? '0 : r_index + IW'(1);
    assign w_is_nxt   = w_legal && (w_idx == w_nxt);
    assign w_is_hold  = w_legal && (w_idx == r_index);
    assign w_in_order = w_is_nxt || (ALLOW_HOLD && w_is_hold);

    always_comb begin
        w_state_d     = r_state;
        w_run_d       = r_run;
        w_seq_err_d   = 1'b0;
        w_err_count_d = r_err_count;
        if (code_valid) begin
            unique case (r_state)
                StUnlocked: begin
                    if (!w_legal) begin
                        w_run_d = '0;
                    end else if ((r_run == '0) || w_is_nxt) begin
                        w_run_d = r_run + RW'(1);
                    end else begin
                        w_run_d = RW'(1);
                    end
                    if (w_legal && (w_run_d >= RW'(LOCK_COUNT))) begin
                        w_state_d = StLocked;
                    end
                end
                StLocked: begin
                    if (!w_in_order) begin
                        w_seq_err_d = 1'b1;
                        w_state_d   = StUnlocked;
                        w_run_d     = w_legal ? RW'(1) : '0;
                        if (r_err_count != 8'hff) begin
                            w_err_count_d = r_err_count + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_d = StUnlocked;
                    w_run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state     <= StUnlocked;
            r_run       <= '0;
            r_index     <= '0;
            r_legal     <= 1'b0;
            r_out_valid <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_d;
            r_run       <= w_run_d;
            r_out_valid <= code_valid;
            r_seq_err   <= w_seq_err_d;
            r_err_count <= w_err_count_d;
            if (code_valid) begin
                r_legal <= w_legal;
                if (w_legal) begin
                    r_index <= w_idx;
                end
            end
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NSTATES; i++) begin
            onehot[i] = r_out_valid && r_legal && (r_index == IW'(i));
        end
    end

    assign index     = r_index;
    assign out_valid = r_out_valid;
    assign legal     = r_legal;
    assign seq_err   = r_seq_err;
    assign locked    = (r_state == StLocked);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: scenario tasks plus randomized traffic compared
// against a table-driven reference model; two instances cover ALLOW_HOLD = 1 and 0.
module tb_johnson_decoder;

    localparam int W  = 5;
    localparam int N  = 2 * W;
    localparam int IW = 4;
    localparam int LC = 2;

    logic          clk = 1'b0;
    logic          clear;
    logic [W-1:0]  code;
    logic          code_valid;

    // h_* : ALLOW_HOLD = 1, s_* : ALLOW_HOLD = 0
    logic [IW-1:0] h_index, s_index;
    logic [N-1:0]  h_onehot, s_onehot;
    logic          h_out_valid, s_out_valid, h_legal, s_legal;
    logic          h_seq_err, s_seq_err, h_locked, s_locked;
    logic [7:0]    h_err_count, s_err_count;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] tbl [N];

    // Reference model; per-FSM arrays are indexed [0]=no hold, [1]=hold allowed.
    int m_index, m_legal, m_ov;
    int m_locked [2];
    int m_run    [2];
    int m_cnt    [2];
    int m_seq    [2];

    johnson_decoder #(.WIDTH(W), .IW(IW), .LOCK_COUNT(LC), .ALLOW_HOLD(1'b1)) u_dut_h (
        .clk(clk), .clear(clear), .code(code), .code_valid(code_valid),
        .index(h_index), .onehot(h_onehot), .out_valid(h_out_valid), .legal(h_legal),
        .seq_err(h_seq_err), .locked(h_locked), .err_count(h_err_count)
    );

    johnson_decoder #(.WIDTH(W), .IW(IW), .LOCK_COUNT(LC), .ALLOW_HOLD(1'b0)) u_dut_s (
        .clk(clk), .clear(clear), .code(code), .code_valid(code_valid),
        .index(s_index), .onehot(s_onehot), .out_valid(s_out_valid), .legal(s_legal),
        .seq_err(s_seq_err), .locked(s_locked), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    function automatic int lookup(input logic [W-1:0] c);
        for (int k = 0; k < N; k++) begin
            if (tbl[k] == c) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_index = 0; m_legal = 0; m_ov = 0;
        for (int h = 0; h < 2; h++) begin
            m_locked[h] = 0; m_run[h] = 0; m_cnt[h] = 0; m_seq[h] = 0;
        end
    endtask

    task automatic model_update(input logic [W-1:0] c, input logic v);
        int k;
        int prev;
        k    = lookup(c);
        prev = m_index;
        for (int h = 0; h < 2; h++) m_seq[h] = 0;
        if (!v) begin
            m_ov = 0;
            return;
        end
        m_ov    = 1;
        m_legal = (k >= 0);
        if (k >= 0) m_index = k;
        for (int h = 0; h < 2; h++) begin
            if (m_locked[h] == 0) begin
                if (k < 0) m_run[h] = 0;
                else if (m_run[h] == 0 || k == (prev + 1) % N) m_run[h]++;
                else m_run[h] = 1;
                if (m_run[h] >= LC) m_locked[h] = 1;
            end else if (!(k >= 0 && (k == (prev + 1) % N || (h == 1 && k == prev)))) begin
                m_seq[h]    = 1;
                m_cnt[h]    = (m_cnt[h] < 255) ? m_cnt[h] + 1 : 255;
                m_locked[h] = 0;
                m_run[h]    = (k >= 0) ? 1 : 0;
            end
        end
    endtask

    task automatic step(input logic [W-1:0] c, input logic v);
        code       = c;
        code_valid = v;
        @(posedge clk);
        #1;
        model_update(c, v);
    endtask

    task automatic do_reset();
        clear      = 1'b1;
        code       = '0;
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [IW+N+12:0] h_all, s_all;
        clear      = 1'b1;
        code       = 5'b11111;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        h_all = {h_index, h_onehot, h_out_valid, h_legal, h_seq_err, h_locked, h_err_count};
        s_all = {s_index, s_onehot, s_out_valid, s_legal, s_seq_err, s_locked, s_err_count};
        n_vec++;
        if (h_all !== '0) begin
            n_err++; $display("FAIL reset_h: got %h want 0", h_all);
        end
        n_vec++;
        if (s_all !== '0) begin
            n_err++; $display("FAIL reset_s: got %h want 0", s_all);
        end
        clear = 1'b0;
        model_reset();
        step(5'b11111, 1'b1);
        n_vec++;
        if ({h_index, h_legal, h_out_valid, h_locked} !== {4'd5, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL first_code: idx/legal/ov/lock got %0d/%b/%b/%b want 5/1/1/0",
                     h_index, h_legal, h_out_valid, h_locked);
        end
    endtask

    task automatic test_lock_wrap();
        logic [N-1:0] e;
        do_reset();
        for (int k = 0; k <= N; k++) begin
            step(tbl[k % N], 1'b1);
            e = '0;
            e[k % N] = 1'b1;
            n_vec++;
            if (h_index !== IW'(k % N) || h_onehot !== e) begin
                n_err++;
                $display("FAIL wrap_decode[%0d]: idx %0d onehot %h want %0d %h",
                         k, h_index, h_onehot, k % N, e);
            end
            n_vec++;
            if (h_locked !== (k >= 1) || h_seq_err !== 1'b0 || s_locked !== (k >= 1)) begin
                n_err++;
                $display("FAIL wrap_lock[%0d]: locked %b/%b seq_err %b want %b/%b 0",
                         k, h_locked, s_locked, h_seq_err, k >= 1, k >= 1);
            end
        end
        n_vec++;
        if (h_err_count !== 8'd0) begin
            n_err++; $display("FAIL wrap_errcnt: got %0d want 0", h_err_count);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        step(tbl[0], 1'b1);
        step(tbl[1], 1'b1);
        step(tbl[2], 1'b1);
        step(5'b00101, 1'b1);
        n_vec++;
        if ({h_legal, h_onehot, h_index} !== {1'b0, 10'h000, 4'd2}) begin
            n_err++;
            $display("FAIL illegal_decode: legal %b onehot %h idx %0d want 0 000 2",
                     h_legal, h_onehot, h_index);
        end
        n_vec++;
        if ({h_seq_err, h_locked, h_err_count} !== {1'b1, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL illegal_err: seq_err %b locked %b cnt %0d want 1 0 1",
                     h_seq_err, h_locked, h_err_count);
        end
        step(5'b00111, 1'b1);
        n_vec++;
        if ({h_seq_err, h_index, h_locked} !== {1'b0, 4'd3, 1'b0}) begin
            n_err++;
            $display("FAIL relock_a: seq_err %b idx %0d locked %b want 0 3 0",
                     h_seq_err, h_index, h_locked);
        end
        step(5'b01111, 1'b1);
        n_vec++;
        if ({h_index, h_locked, h_err_count} !== {4'd4, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL relock_b: idx %0d locked %b cnt %0d want 4 1 1",
                     h_index, h_locked, h_err_count);
        end
    endtask

    task automatic test_skip_hold();
        do_reset();
        step(5'b00001, 1'b1);
        step(5'b00011, 1'b1);
        step(5'b01111, 1'b1);
        n_vec++;
        if ({h_seq_err, h_err_count, s_seq_err, s_err_count} !== {1'b1, 8'd1, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL skip: seq_err %b/%b cnt %0d/%0d want 1/1 1/1",
                     h_seq_err, s_seq_err, h_err_count, s_err_count);
        end
        step(5'b11111, 1'b1);
        step(5'b11110, 1'b1);
        step(5'b11100, 1'b1);
        step(5'b11100, 1'b1);
        n_vec++;
        if ({h_seq_err, h_locked, h_err_count} !== {1'b0, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL hold_allowed: seq_err %b locked %b cnt %0d want 0 1 1",
                     h_seq_err, h_locked, h_err_count);
        end
        n_vec++;
        if ({s_seq_err, s_locked, s_err_count} !== {1'b1, 1'b0, 8'd2}) begin
            n_err++;
            $display("FAIL hold_strict: seq_err %b locked %b cnt %0d want 1 0 2",
                     s_seq_err, s_locked, s_err_count);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        step(tbl[0], 1'b1);
        step(tbl[1], 1'b0);
        n_vec++;
        if ({h_out_valid, h_index, h_onehot} !== {1'b0, 4'd0, 10'h000}) begin
            n_err++;
            $display("FAIL gap_idle: ov %b idx %0d onehot %h want 0 0 000",
                     h_out_valid, h_index, h_onehot);
        end
        step(tbl[1], 1'b1);
        n_vec++;
        if ({h_out_valid, h_index, h_locked, h_seq_err} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL gap_resume: ov %b idx %0d locked %b seq_err %b want 1 1 1 0",
                     h_out_valid, h_index, h_locked, h_seq_err);
        end
        step(W'($urandom), 1'b0);
        step(tbl[2], 1'b1);
        n_vec++;
        if ({h_out_valid, h_index, h_locked, h_err_count} !== {1'b1, 4'd2, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL gap_order: ov %b idx %0d locked %b cnt %0d want 1 2 1 0",
                     h_out_valid, h_index, h_locked, h_err_count);
        end
    endtask

    task automatic test_saturation();
        int k;
        do_reset();
        step(tbl[0], 1'b1);
        step(tbl[1], 1'b1);
        k = 1;
        for (int i = 0; i < 300; i++) begin
            k = (k + 3) % N;
            step(tbl[k], 1'b1);
            k = (k + 1) % N;
            step(tbl[k], 1'b1);
        end
        n_vec++;
        if (h_err_count !== 8'd255 || s_err_count !== 8'd255) begin
            n_err++;
            $display("FAIL saturate: cnt %0d/%0d want 255", h_err_count, s_err_count);
        end
        n_vec++;
        if (h_locked !== 1'b1) begin
            n_err++; $display("FAIL saturate_lock: got %b want 1", h_locked);
        end
    endtask

    task automatic test_async_clear();
        do_reset();
        step(tbl[0], 1'b1);
        step(tbl[1], 1'b1);
        step(tbl[4], 1'b1);
        step(tbl[5], 1'b1);
        n_vec++;
        if ({h_locked, h_err_count} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL pre_clear: locked %b cnt %0d want 1 1", h_locked, h_err_count);
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_vec++;
        if ({h_locked, h_err_count, h_out_valid} !== {1'b0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_clear: locked %b cnt %0d ov %b want 0 0 0",
                     h_locked, h_err_count, h_out_valid);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [W-1:0]     c;
        logic             v;
        int               r;
        logic [N-1:0]     eoh;
        logic [IW+N+12:0] got, exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(99);
            v = 1'b1;
            if (r < 45) c = tbl[(m_index + 1) % N];
            else if (r < 55) c = tbl[m_index];
            else if (r < 70) c = tbl[$urandom_range(N - 1)];
            else if (r < 82) begin
                c = W'($urandom);
                while (lookup(c) >= 0) c = W'($urandom);
            end else begin
                c = W'($urandom);
                v = 1'b0;
            end
            step(c, v);
            eoh = '0;
            if (m_ov != 0 && m_legal != 0) eoh[m_index] = 1'b1;
            for (int h = 0; h < 2; h++) begin
                exp = {IW'(m_index), eoh, m_ov[0], m_legal[0], m_seq[h][0], m_locked[h][0],
                       8'(m_cnt[h])};
                got = (h == 1) ?
                    {h_index, h_onehot, h_out_valid, h_legal, h_seq_err, h_locked, h_err_count} :
                    {s_index, s_onehot, s_out_valid, s_legal, s_seq_err, s_locked, s_err_count};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random[%0d] hold=%0d code=%b v=%b: got %h want %h",
                             i, h, c, v, got, exp);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            if (k <= W) tbl[k] = W'((1 << k) - 1);
            else tbl[k] = W'(((1 << W) - 1) ^ ((1 << (k - W)) - 1));
        end
        model_reset();
        test_reset();
        test_lock_wrap();
        test_illegal();
        test_skip_hold();
        test_gaps();
        test_saturation();
        test_async_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
